decade_sequencer: RTL and testbench
===================================

# decade_sequencer

Run/pause/clear controller for the two-digit BCD decade counter. It owns a single prescaler on the 50 MHz `clk` and produces one-cycle clock-enable ticks at a selectable rate; no derived clocks. It sequences counting with a small state machine and exposes the digits to the 7-segment decoders. It replaces ad-hoc toggled slow clocks in the counter datapath.

## Interface
- `FAST_DIV`, 5000000: prescaler period in `clk` cycles when `rate_sel`=1 (10 Hz at 50 MHz).
- `SLOW_DIV`, 50000000: prescaler period when `rate_sel`=0 (1 Hz).
- `PW`, 26: prescaler width; must satisfy 2^PW ≥ max(FAST_DIV, SLOW_DIV).
- `clk` in 1: system clock (50 MHz).
- `reset` in 1: reset, asynchronous, active-low.
- `start` in 1: level, synchronous to `clk`; rising edge requests run.
- `stop` in 1: level, synchronous; rising edge requests pause.
- `clear` in 1: level, synchronous; rising edge zeroes the count and returns to idle.
- `rate_sel` in 1: 0 = SLOW_DIV, 1 = FAST_DIV.
- `up_down` in 1: 1 = count up, 0 = count down.
- `tick` out 1: one-cycle enable pulse; the count updates at the edge that ends this cycle.
- `units` out 4: BCD units digit, 0–9.
- `tens` out 4: BCD tens digit, 0–9.
- `carry` out 1: one-cycle pulse, registered, on wrap 99→00 (up) or 00→99 (down).
- `running` out 1: high in RUN.
- `state` out 2: IDLE=00, RUN=01, PAUSE=10; 11 unused.

## Operation
- Edge detect: one register per `start`, `stop` and `clear`. An edge is `in & ~prev`. External synchronizers are the integrator's responsibility.
- Request priority in the same cycle: clear > stop > start.
- State transitions:
  - IDLE: start→RUN.
  - RUN: stop→PAUSE.
  - PAUSE: start→RUN.
  - Any state: clear→IDLE, digits := 00, prescaler := 0.
  - Stop in IDLE and start in RUN are ignored.
- Prescaler `pre`, width PW:
  - Counts only in RUN. When `pre` == DIV−1 it wraps to 0.
  - Holds its value in PAUSE, so resume continues the partial period.
  - Forced to 0 in IDLE.
- `tick` = (state==RUN) && (pre==DIV−1), decoded from registers.
- Rate change: `rate_sel` is registered. When the registered value differs from the input, `pre` := 0 on that edge and no tick is issued in that cycle.
- BCD update on tick:
  - Up: units+1; 9 wraps to 0 and increments tens; 99 wraps to 00 and sets `carry`=1 for the next cycle.
  - Down: the mirror; 00 wraps to 99 and sets `carry`.
  - Digits never leave 0–9.
- A stop or clear edge in the same cycle as a tick wins; no count update occurs.
- `running` = (state==RUN).

## Timing
- Reset values: state IDLE, units=tens=0, tick=0, carry=0, running=0, pre=0, edge registers 0, registered rate_sel 0.
- The state changes at the first posedge where the edge is seen. `running` is high from the next cycle.
- RUN is entered at edge E with pre=0. `tick` is high during the cycle after edge E+DIV−1. The first digit update is at edge E+DIV. Period is exactly DIV cycles.
- `carry` is high for the one cycle after the wrap edge.
- `reset` asserted mid-count clears everything immediately (asynchronous). Deassertion is synchronized externally.

## Configuration
- `SEQ_AUTOSTOP_EN` defined: on any wrap (carry set), the state goes to IDLE on the same edge. Digits hold the wrapped value (00 up, 99 down) and `pre` := 0. A new start edge is required to continue.
- Not defined: wrap continues counting in RUN.

## Test plan
- Reset, then start with SLOW_DIV=10 and up_down=1: tick every 10 cycles; units 0→1 at edge E+10; after 100 ticks the digits read 00 and `carry` pulses once.
- Stop at pre=4, then start 7 cycles later: the first tick after resume arrives 5 cycles after the RUN edge; the count does not change while paused.
- Start, stop and clear rising in the same cycle while in RUN: state=IDLE, digits 00, tick stays low.
- up_down=0 from 00 with FAST_DIV=4: first tick gives 99 with `carry`=1; the next tick gives 98.
- Toggle rate_sel mid-period (pre=7, SLOW_DIV=10 → FAST_DIV=4): pre resets; the next tick comes 4 cycles later.
- Build with `SEQ_AUTOSTOP_EN`: count from 98 up gives 99, then 00 with carry; state=IDLE; further cycles hold 00 until start.

Source files
------------

// File: rtl/decade_sequencer.sv
// Run/pause/clear sequencer for the two-digit BCD decade counter: prescaled tick enable, edge-detected controls.
// Optional macro SEQ_AUTOSTOP_EN: a 99->00 / 00->99 wrap returns the sequencer to IDLE.
module decade_sequencer #(
  parameter int FAST_DIV = 5000000,
  parameter int SLOW_DIV = 50000000,
  parameter int PW       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       rate_sel,
  input  logic       up_down,
  output logic       tick,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic       carry,
  output logic       running,
  output logic [1:0] state
);
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] pre_reg, pre_next, pre_last;
  logic [3:0]    units_reg, units_next;
  logic [3:0]    tens_reg, tens_next;
  logic          carry_reg, carry_next;
  logic          rate_reg;
  logic [2:0]    req, req_edge;
  logic          start_edge, stop_edge, clear_edge;
  logic          rate_change, tick_int, count_en, wrap;

  // One previous-value register per control: {clear, stop, start}.
  assign req = {clear, stop, start};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi = gi + 1) begin : g_edge
      logic prev_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_reg <= 1'b0;
        else        prev_reg <= req[gi];
      end
      assign req_edge[gi] = req[gi] & ~prev_reg;
    end
  endgenerate

  assign start_edge = req_edge[0];
  assign stop_edge  = req_edge[1];
  assign clear_edge = req_edge[2];

  assign pre_last    = rate_reg ? PW'(FAST_DIV - 1) : PW'(SLOW_DIV - 1);
  assign rate_change = (rate_sel != rate_reg);
  assign tick_int    = (state_reg == RUN) && (pre_reg == pre_last) && !rate_change;
  // A stop or clear landing on a tick cycle suppresses the count update.
  assign count_en    = tick_int && !stop_edge && !clear_edge;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      pre_reg   <= '0;
      units_reg <= '0;
      tens_reg  <= '0;
      carry_reg <= 1'b0;
      rate_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pre_reg   <= pre_next;
      units_reg <= units_next;
      tens_reg  <= tens_next;
      carry_reg <= carry_next;
      rate_reg  <= rate_sel;
    end
  end

  always_comb begin
    units_next = units_reg;
    tens_next  = tens_reg;
    wrap       = 1'b0;
    if (clear_edge) begin
      units_next = 4'd0;
      tens_next  = 4'd0;
    end else if (count_en) begin
      if (up_down) begin
        if (units_reg == 4'd9) begin
          units_next = 4'd0;
          if (tens_reg == 4'd9) begin
            tens_next = 4'd0;
            wrap      = 1'b1;
          end else begin
            tens_next = tens_reg + 4'd1;
          end
        end else begin
          units_next = units_reg + 4'd1;
        end
      end else begin
        if (units_reg == 4'd0) begin
          units_next = 4'd9;
          if (tens_reg == 4'd0) begin
            tens_next = 4'd9;
            wrap      = 1'b1;
          end else begin
            tens_next = tens_reg - 4'd1;
          end
        end else begin
          units_next = units_reg - 4'd1;
        end
      end
    end
  end

  assign carry_next = wrap;

  always_comb begin
    state_next = state_reg;
    if (clear_edge) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start_edge && !stop_edge) state_next = RUN;
        RUN: begin
          if (stop_edge) state_next = PAUSE;
`ifdef SEQ_AUTOSTOP_EN
          else if (wrap) state_next = IDLE;
`endif
        end
        PAUSE:   if (start_edge && !stop_edge) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Prescaler advances only across RUN->RUN edges, so a pause keeps the partial period.
  always_comb begin
    pre_next = pre_reg;
    if (state_next == IDLE || rate_change) begin
      pre_next = '0;
    end else if (state_reg == RUN && state_next == RUN) begin
      pre_next = (pre_reg == pre_last) ? '0 : pre_reg + PW'(1);
    end
  end

  assign tick    = tick_int;
  assign units   = units_reg;
  assign tens    = tens_reg;
  assign carry   = carry_reg;
  assign running = (state_reg == RUN);
  assign state   = state_reg;

endmodule

// File: tb/tb_decade_sequencer.sv
// Bench for decade_sequencer: directed scenarios plus random control traffic against a count-level model.
module tb_decade_sequencer;
  localparam int FDIV = 4;
  localparam int SDIV = 10;
`ifdef SEQ_AUTOSTOP_EN
  localparam bit AUTOSTOP = 1'b1;
`else
  localparam bit AUTOSTOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic       rate_sel = 1'b0, up_down = 1'b1;
  logic       tick, carry, running;
  logic [3:0] units, tens;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  // Reference model: current registered view (state 0 idle / 1 run / 2 pause, count 0..99).
  int m_state, m_count, m_pre, m_rate, m_carry;
  int p_start, p_stop, p_clear;
  logic obs_tick;
  int ticks, carries, lat, n;
  bit found;
  bit r_st, r_sp, r_cl, r_rs, r_ud;

  decade_sequencer #(.FAST_DIV(FDIV), .SLOW_DIV(SDIV), .PW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .rate_sel(rate_sel), .up_down(up_down), .tick(tick), .units(units),
    .tens(tens), .carry(carry), .running(running), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_count = 0; m_pre = 0; m_rate = 0; m_carry = 0;
    p_start = 0; p_stop = 0; p_clear = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".units"},   32'(units),   32'(m_count % 10));
    check({tag, ".tens"},    32'(tens),    32'(m_count / 10));
    check({tag, ".carry"},   32'(carry),   32'(m_carry));
    check({tag, ".running"}, 32'(running), 32'(m_state == 1));
    check({tag, ".state"},   32'(state),   32'(m_state));
  endtask

  // One clock cycle: drive, check mid-cycle, then advance the model over the edge.
  task automatic step(input bit st, input bit sp, input bit cl, input bit rs, input bit ud);
    int div, ns, exp_tick;
    bit se, pe, ce, adv, wrapped;
    start = st; stop = sp; clear = cl; rate_sel = rs; up_down = ud;
    #1;
    se = st && (p_start == 0);
    pe = sp && (p_stop == 0);
    ce = cl && (p_clear == 0);
    div = (m_rate != 0) ? FDIV : SDIV;
    exp_tick = (m_state == 1 && m_pre == div - 1 && int'(rs) == m_rate) ? 1 : 0;
    obs_tick = tick;
    check("tick", 32'(tick), 32'(exp_tick));
    check_regs("cyc");
    adv = (exp_tick != 0) && !pe && !ce;
    wrapped = 1'b0;
    ns = m_state;
    if (ce) ns = 0;
    else if (m_state == 1 && pe) ns = 2;
    else if (m_state != 1 && se && !pe) ns = 1;
    @(posedge clk);
    if (adv) begin
      wrapped = ud ? (m_count == 99) : (m_count == 0);
      m_count = ud ? (m_count + 1) % 100 : (m_count + 99) % 100;
      if (wrapped && AUTOSTOP) ns = 0;
    end
    if (ce) m_count = 0;
    if (ns == 0 || int'(rs) != m_rate) m_pre = 0;
    else if (m_state == 1 && ns == 1) m_pre = (m_pre + 1) % div;
    m_state = ns;
    m_carry = wrapped ? 1 : 0;
    m_rate  = int'(rs);
    p_start = int'(st); p_stop = int'(sp); p_clear = int'(cl);
    @(negedge clk);
  endtask

  // Steps with controls low until a tick is seen; k is the step index of that tick.
  task automatic wait_tick(input string tag, input int bound, output int k);
    bit hit;
    hit = 1'b0;
    k = 0;
    for (int i = 1; i <= bound && !hit; i++) begin
      step(1'b0, 1'b0, 1'b0, rate_sel, up_down);
      if (obs_tick === 1'b1) begin
        hit = 1'b1;
        k = i;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $error("FAIL %s: observed no tick expected tick within %0d cycles", tag, bound);
    end
  endtask

  initial begin
    // Asynchronous reset state
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("reset.tick", 32'(tick), 32'd0);
    check_regs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Slow rate, count up through a full 100-tick wrap
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    ticks = 0; carries = 0;
    for (int i = 0; i < 1000; i++) begin
      step(0, 0, 0, 0, 1);
      if (obs_tick === 1'b1) ticks++;
      if (carry === 1'b1) carries++;
    end
    check("wrap.ticks", 32'(ticks), 32'd100);
    check("wrap.carries", 32'(carries), 32'd1);
    check("wrap.digits", 32'({tens, units}), 32'h00);

    // Pause at pre=4, resume after a gap: remaining five edges to the tick
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    n = 0;
    while (!(m_state == 1 && m_pre == 4) && n < 50) begin
      step(0, 0, 0, 0, 1);
      n++;
    end
    step(0, 1, 0, 0, 1);
    n = m_count;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    check("pause.digits", 32'(tens * 10 + units), 32'(n));
    check("pause.state", 32'(state), 32'd2);
    step(1, 0, 0, 0, 1);
    wait_tick("resume", 20, lat);
    check("resume.edges", 32'(lat - 1), 32'd5);

    // Rate change at pre=7: prescaler restarts at the fast rate
    n = 0;
    while (!(m_state == 1 && m_pre == 7) && n < 50) begin
      step(0, 0, 0, 0, 1);
      n++;
    end
    step(0, 0, 0, 1, 1);
    wait_tick("rate", 20, lat);
    check("rate.cycles", 32'(lat), 32'd4);

    // Count down from 00 at the fast rate
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    wait_tick("down1", 20, lat);
    check("down1.digits", 32'({tens, units}), 32'h99);
    check("down1.carry", 32'(carry), 32'd1);
    if (AUTOSTOP) begin
      step(0, 0, 0, 1, 0);
      check("down.autostop_state", 32'(state), 32'd0);
      check("down.autostop_digits", 32'({tens, units}), 32'h99);
    end else begin
      wait_tick("down2", 20, lat);
      check("down2.digits", 32'({tens, units}), 32'h98);
      check("down2.carry", 32'(carry), 32'd0);
    end

    // Start, stop and clear rising together while running
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(1, 1, 1, 1, 1);
    check("triple.state", 32'(state), 32'd0);
    check("triple.digits", 32'({tens, units}), 32'h00);
    step(0, 0, 0, 1, 1);
    check("triple.tick", 32'(tick), 32'd0);

    // Count 98 -> 99 -> 00 at the fast rate
    step(1, 0, 0, 1, 1);
    n = 0;
    while (m_count != 98 && n < 2000) begin
      step(0, 0, 0, 1, 1);
      n++;
    end
    wait_tick("to99", 20, lat);
    check("to99.digits", 32'({tens, units}), 32'h99);
    wait_tick("to00", 20, lat);
    check("to00.digits", 32'({tens, units}), 32'h00);
    check("to00.carry", 32'(carry), 32'd1);
    if (AUTOSTOP) begin
      check("autostop.state", 32'(state), 32'd0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);
      check("autostop.hold", 32'({tens, units}), 32'h00);
      check("autostop.idle", 32'(state), 32'd0);
    end else begin
      check("wrap.run", 32'(state), 32'd1);
    end

    // Random control traffic
    r_st = 0; r_sp = 0; r_cl = 0; r_rs = rate_sel; r_ud = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) r_st = ~r_st;
      if ($urandom_range(0, 11) == 0) r_sp = ~r_sp;
      r_cl = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) r_rs = ~r_rs;
      if ($urandom_range(0, 49) == 0) r_ud = ~r_ud;
      step(r_st, r_sp, r_cl, r_rs, r_ud);
    end

    // Asynchronous reset while counting
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("midreset.tick", 32'(tick), 32'd0);
    check_regs("midreset");
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 25; i++) step(0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
